lut_cfg_loader: RTL and testbench

- Configuration sequencer for a bank of fracturable dual-LUT slices.
- Accepts configuration as a valid/ready byte stream and assembles each slice's full frame: {split bit, lower LUT mem, upper LUT mem}.
- Drives the shared config_in bus and a one-hot per-slice config_en strobe, one slice at a time.
- Sits between the bitstream source (scan/JTAG bridge or boot ROM reader) and the slice array; all logic runs on config_clk.

---
 rtl/lut_cfg_pkg.sv | 21 ++
 rtl/lut_cfg_frame_asm.sv | 66 ++++++
 rtl/lut_cfg_loader.sv | 122 ++++++++++++
 tb/tb_lut_cfg_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared state encoding and frame-geometry helpers for the LUT configuration loader;
// the bitstream generator test model imports the same functions.
package lut_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Frame = {split bit, lower LUT mem, upper LUT mem}
   function automatic int cfg_width(input int inputs);
      return 2 * (1 << inputs) + 1;
   endfunction

   function automatic int words_per_frame(input int cfg_w, input int word_w);
      return (cfg_w + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/lut_cfg_frame_asm.sv
// Word-to-frame assembler: writes each accepted word into its frame slot, pulses frame_done on the
// last word (1-cycle registered frame); LUT_CFG_CHECK_EN adds a trailing even-parity word.
module lut_cfg_frame_asm
   import lut_cfg_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int CFG_W  = 33,
   parameter int WPF    = words_per_frame(CFG_W, WORD_W)
)(
   input  logic              config_clk,
   input  logic              config_rst,
   input  logic              clr,
   input  logic              accept,
   input  logic [WORD_W-1:0] word,
   output logic [CFG_W-1:0]  frame,
`ifdef LUT_CFG_CHECK_EN
   output logic              frame_bad,
`endif
   output logic              frame_done
);

`ifdef LUT_CFG_CHECK_EN
   localparam int TOTAL_WORDS = WPF + 1;
`else
   localparam int TOTAL_WORDS = WPF;
`endif
   localparam int WCNT_W = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
   localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(TOTAL_WORDS - 1);

   logic [WCNT_W-1:0] wcnt;
   logic              last_word;

   assign last_word = accept && (wcnt == LAST_WCNT);

   always_ff @(posedge config_clk) begin
      if (config_rst || clr) begin
         wcnt <= '0;
      end else if (accept) begin
         wcnt <= last_word ? '0 : wcnt + WCNT_W'(1);
      end
   end

   // Per-bit slot decode; bits of the last word past CFG_W have no home and fall away.
   always_ff @(posedge config_clk) begin
      if (config_rst) begin
         frame <= '0;
      end else if (accept) begin
         for (int b = 0; b < CFG_W; b++) begin
            if (wcnt == WCNT_W'(b / WORD_W)) begin
               frame[b] <= word[b % WORD_W];
            end
         end
      end
   end

`ifdef LUT_CFG_CHECK_EN
   logic parity_ok;

   assign parity_ok  = (word[0] == ^frame);
   assign frame_done = last_word && parity_ok;
   assign frame_bad  = last_word && !parity_ok;
`else
   assign frame_done = last_word;
`endif

endmodule

// File: rtl/lut_cfg_loader.sv
// Sequences full frames into NUM_SLICES LUT slices: config_en one cycle after a frame's last word;
// in_ready only in LOAD, in_valid low stalls forever. LUT_CFG_CHECK_EN enables per-frame parity and err.
module lut_cfg_loader
   import lut_cfg_pkg::*;
#(
   parameter int INPUTS          = 4,
   parameter int NUM_SLICES      = 4,
   parameter int WORD_W          = 8,
   parameter int CFG_W           = cfg_width(INPUTS),
   parameter int WORDS_PER_FRAME = words_per_frame(CFG_W, WORD_W)
)(
   input  logic                  config_clk,
   input  logic                  config_rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [WORD_W-1:0]     in_data,
   output logic                  in_ready,
   output logic [CFG_W-1:0]      config_in,
   output logic [NUM_SLICES-1:0] config_en,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   state_t                state;
   state_t                state_nxt;
   logic [IDX_W-1:0]      idx;
   logic                  start_acc;
   logic                  accept;
   logic                  frame_done;
   logic                  last_slice;
   logic [NUM_SLICES-1:0] en_onehot;
`ifdef LUT_CFG_CHECK_EN
   logic                  frame_bad;
`endif

   assign start_acc  = (state == IDLE) && start;
   assign accept     = in_valid && in_ready;
   assign last_slice = (idx == LAST_IDX);

   lut_cfg_frame_asm #(
      .WORD_W (WORD_W),
      .CFG_W  (CFG_W),
      .WPF    (WORDS_PER_FRAME)
   ) u_frame_asm (
      .config_clk (config_clk),
      .config_rst (config_rst),
      .clr        (start_acc),
      .accept     (accept),
      .word       (in_data),
      .frame      (config_in),
`ifdef LUT_CFG_CHECK_EN
      .frame_bad  (frame_bad),
`endif
      .frame_done (frame_done)
   );

   always_ff @(posedge config_clk) begin
      if (config_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    if (frame_done) state_nxt = COMMIT;
         COMMIT:  state_nxt = last_slice ? FINISH : LOAD;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == LOAD);
      en_onehot = '0;
      en_onehot[idx] = 1'b1;
   end

   // config_en is registered off frame_done, so it is high exactly during COMMIT.
   always_ff @(posedge config_clk) begin
      if (config_rst) begin
         idx       <= '0;
         config_en <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         config_en <= frame_done ? en_onehot : '0;
         if (start_acc) begin
            idx  <= '0;
            busy <= 1'b1;
            done <= 1'b0;
         end
         if ((state == COMMIT) && !last_slice) begin
            idx <= idx + IDX_W'(1);
         end
         if (state == FINISH) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

`ifdef LUT_CFG_CHECK_EN
   always_ff @(posedge config_clk) begin
      if (config_rst || start_acc) begin
         err <= 1'b0;
      end else if (frame_bad) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Randomized bench for lut_cfg_loader (2 slices, default geometry); frame contents and strobe
// timing are predicted from the stream format, and a monitor logs every config_en pulse.
`timescale 1ns/1ps
module tb_lut_cfg_loader;

   localparam int INPUTS = 4;
   localparam int NS     = 2;
   localparam int WORD_W = 8;
   localparam int CFG_W  = 2 * (2 ** INPUTS) + 1;
   localparam int WPF    = (CFG_W + WORD_W - 1) / WORD_W;
`ifdef LUT_CFG_CHECK_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif
   localparam int WPS       = WPF + CHK;   // stream words per slice
   localparam int SLICE_CYC = WPS + 1;     // back-to-back cycles per slice

   logic              clk;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;
   logic [CFG_W-1:0]  config_in;
   logic [NS-1:0]     config_en;
   logic              busy;
   logic              done;
   logic              err;

   int tests = 0;
   int fails = 0;

   lut_cfg_loader #(
      .INPUTS     (INPUTS),
      .NUM_SLICES (NS),
      .WORD_W     (WORD_W)
   ) dut (
      .config_clk (clk),
      .config_rst (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .config_in  (config_in),
      .config_en  (config_en),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NS-1:0]    mon_en[$];
   logic [CFG_W-1:0] mon_cfg[$];
   int               mon_cyc[$];
   int               multi_hot = 0;

   always @(negedge clk) begin
      if (config_en != '0) begin
         mon_en.push_back(config_en);
         mon_cfg.push_back(config_in);
         mon_cyc.push_back(cyc);
      end
      if ($countones(config_en) > 1) multi_hot++;
   end

   logic [CFG_W-1:0]  frm[NS];
   logic [WORD_W-1:0] junk[NS];

   // Stream word k of frame f: data slices LSB first, then (checked builds) the parity word.
   function automatic logic [WORD_W-1:0] word_of(input logic [CFG_W-1:0] f, input int k,
                                                 input logic [WORD_W-1:0] j, input bit corrupt);
      logic [WPF*WORD_W-1:0] padded;
      logic [WORD_W-1:0]     w;
      padded = (WPF*WORD_W)'(f);
      if (k < WPF) begin
         w = padded[k*WORD_W +: WORD_W];
         for (int b = 0; b < WORD_W; b++)
            if (k*WORD_W + b >= CFG_W) w[b] = j[b];
      end else begin
         w = j;
         w[0] = (^f) ^ corrupt;
      end
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_mon();
      mon_en.delete();
      mon_cfg.delete();
      mon_cyc.delete();
   endtask

   task automatic new_frames();
      for (int s = 0; s < NS; s++) begin
         frm[s]  = CFG_W'({$urandom(), $urandom()});
         junk[s] = WORD_W'($urandom());
      end
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL send_word_timeout: in_ready=%0b required 1 within 100 cycles", in_ready);
      end else begin
         tick();
      end
   endtask

   task automatic send_frame(input int s, input bit corrupt, input int first, input int last);
      for (int k = first; k <= last; k++) send_word(word_of(frm[s], k, junk[s], corrupt));
   endtask

   task automatic wait_done(output int at);
      int n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      at = cyc;
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL wait_done: done=%0b required 1 within 100 cycles", done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) tick();
      start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      tick();
      tests += 6;
      if (in_ready !== 1'b0)  begin fails++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
      if (config_en !== '0)   begin fails++; $display("FAIL reset_config_en: got %b required 0", config_en); end
      if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy (start with rst): got %0b required 0", busy); end
      if (done !== 1'b0)      begin fails++; $display("FAIL reset_done: got %0b required 0", done); end
      if (err !== 1'b0)       begin fails++; $display("FAIL reset_err: got %0b required 0", err); end
      if (config_in !== '0)   begin fails++; $display("FAIL reset_config_in: got %h required 0", config_in); end
   endtask

   task automatic test_back_to_back();
      int c0, at;
      logic [NS-1:0] exp_en;
      new_frames();
      clear_mon();
      c0 = cyc;
      pulse_start();
      for (int s = 0; s < NS; s++) send_frame(s, 1'b0, 0, WPS - 1);
      in_valid = 1'b0;
      wait_done(at);
      tests++;
      if (at !== c0 + NS*SLICE_CYC + 2) begin fails++; $display("FAIL b2b_done_cycle: got %0d required %0d", at - c0, NS*SLICE_CYC + 2); end
      tests++;
      if (mon_en.size() !== NS) begin fails++; $display("FAIL b2b_pulse_count: got %0d required %0d", mon_en.size(), NS); end
      for (int i = 0; i < NS && i < mon_en.size(); i++) begin
         exp_en = '0;
         exp_en[i] = 1'b1;
         tests += 3;
         if (mon_en[i] !== exp_en) begin fails++; $display("FAIL b2b_en[%0d]: got %b required %b", i, mon_en[i], exp_en); end
         if (mon_cfg[i] !== frm[i]) begin fails++; $display("FAIL b2b_cfg[%0d]: got %h required %h", i, mon_cfg[i], frm[i]); end
         if (mon_cyc[i] !== c0 + SLICE_CYC*(i+1)) begin
            fails++; $display("FAIL b2b_latency[%0d]: got %0d required %0d", i, mon_cyc[i] - c0, SLICE_CYC*(i+1));
         end
      end
      repeat (3) tick();
      tests += 3;
      if (done !== 1'b1)    begin fails++; $display("FAIL b2b_done_held: got %0b required 1", done); end
      if (busy !== 1'b0)    begin fails++; $display("FAIL b2b_busy_after: got %0b required 0", busy); end
      if (multi_hot !== 0)  begin fails++; $display("FAIL b2b_onehot: got %0d multi-hot cycles required 0", multi_hot); end
   endtask

   task automatic test_split_pattern();
      int at;
      logic [CFG_W-1:0] got;
      new_frames();
      frm[0]  = {1'b1, 32'hA5A5_A5A5};
      junk[0] = 8'hFF;
      clear_mon();
      pulse_start();
      for (int s = 0; s < NS; s++) send_frame(s, 1'b0, 0, WPS - 1);
      in_valid = 1'b0;
      wait_done(at);
      got = (mon_cfg.size() > 0) ? mon_cfg[0] : '0;
      tests += 3;
      if (got[32] !== 1'b1) begin fails++; $display("FAIL split_bit: got %0b required 1", got[32]); end
      if (got[31:0] !== 32'hA5A5_A5A5) begin fails++; $display("FAIL split_mem: got %h required a5a5a5a5", got[31:0]); end
      if (mon_cfg.size() < 2 || mon_cfg[1] !== frm[1]) begin
         fails++; $display("FAIL split_slice1: got %0d pulses, cfg %h required %h", mon_cfg.size(), (mon_cfg.size() > 1) ? mon_cfg[1] : '0, frm[1]);
      end
   endtask

   task automatic test_stall();
      int at, n0, ready_drop;
      new_frames();
      clear_mon();
      pulse_start();
      tests += 2;
      if (done !== 1'b0) begin fails++; $display("FAIL stall_done_cleared: got %0b required 0", done); end
      if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy: got %0b required 1", busy); end
      send_frame(0, 1'b0, 0, 1);
      in_valid = 1'b0;
      n0 = mon_en.size();
      ready_drop = 0;
      for (int i = 0; i < 20; i++) begin
         in_data = WORD_W'($urandom());
         tick();
         if (in_ready !== 1'b1) ready_drop++;
      end
      tests += 2;
      if (ready_drop !== 0) begin fails++; $display("FAIL stall_in_ready: dropped %0d cycles required 0", ready_drop); end
      if (mon_en.size() !== n0) begin fails++; $display("FAIL stall_no_en: got %0d pulses required %0d", mon_en.size(), n0); end
      send_frame(0, 1'b0, 2, WPS - 1);
      send_frame(1, 1'b0, 0, WPS - 1);
      in_valid = 1'b0;
      wait_done(at);
      tests += 2;
      if (mon_cfg.size() < 1 || mon_cfg[0] !== frm[0]) begin fails++; $display("FAIL stall_cfg0: got %0d pulses required frame %h", mon_cfg.size(), frm[0]); end
      if (mon_cfg.size() < 2 || mon_cfg[1] !== frm[1]) begin fails++; $display("FAIL stall_cfg1: got %0d pulses required frame %h", mon_cfg.size(), frm[1]); end
   endtask

   task automatic test_reset_midload();
      int at;
      new_frames();
      clear_mon();
      pulse_start();
      send_frame(0, 1'b0, 0, WPS - 1);
      send_frame(1, 1'b0, 0, 2);
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      tests += 6;
      if (in_ready !== 1'b0)  begin fails++; $display("FAIL midrst_in_ready: got %0b required 0", in_ready); end
      if (config_en !== '0)   begin fails++; $display("FAIL midrst_config_en: got %b required 0", config_en); end
      if (busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %0b required 0", busy); end
      if (done !== 1'b0)      begin fails++; $display("FAIL midrst_done: got %0b required 0", done); end
      if (config_in !== '0)   begin fails++; $display("FAIL midrst_config_in: got %h required 0", config_in); end
      if (mon_en.size() !== 1) begin fails++; $display("FAIL midrst_pulses: got %0d required 1", mon_en.size()); end
      rst = 1'b0;
      tick();
      new_frames();
      clear_mon();
      pulse_start();
      for (int s = 0; s < NS; s++) send_frame(s, 1'b0, 0, WPS - 1);
      in_valid = 1'b0;
      wait_done(at);
      tests += 2;
      if (mon_en.size() < 1 || mon_en[0] !== 2'b01) begin fails++; $display("FAIL midrst_reload_first: got %0d pulses required first en 01", mon_en.size()); end
      if (mon_cfg.size() < 1 || mon_cfg[0] !== frm[0]) begin fails++; $display("FAIL midrst_reload_cfg: got %0d pulses required frame %h", mon_cfg.size(), frm[0]); end
   endtask

   task automatic test_start_ignored();
      int at;
      new_frames();
      clear_mon();
      pulse_start();
      send_frame(0, 1'b0, 0, 1);
      start = 1'b1;
      send_word(word_of(frm[0], 2, junk[0], 1'b0));
      start = 1'b0;
      send_frame(0, 1'b0, 3, WPS - 1);
      send_frame(1, 1'b0, 0, WPS - 1);
      in_valid = 1'b0;
      wait_done(at);
      tests += 3;
      if (mon_en.size() !== NS) begin fails++; $display("FAIL startign_pulses: got %0d required %0d", mon_en.size(), NS); end
      if (mon_cfg.size() < 1 || mon_cfg[0] !== frm[0] || mon_en[0] !== 2'b01) begin fails++; $display("FAIL startign_slice0: got %0d pulses required en 01 frame %h", mon_cfg.size(), frm[0]); end
      if (mon_cfg.size() < 2 || mon_cfg[1] !== frm[1] || mon_en[1] !== 2'b10) begin fails++; $display("FAIL startign_slice1: got %0d pulses required en 10 frame %h", mon_cfg.size(), frm[1]); end
   endtask

`ifdef LUT_CFG_CHECK_EN
   task automatic test_parity();
      int at;
      new_frames();
      clear_mon();
      pulse_start();
      send_frame(0, 1'b1, 0, WPS - 1);
      in_valid = 1'b0;
      tick();
      tests += 3;
      if (err !== 1'b1)        begin fails++; $display("FAIL parity_err_set: got %0b required 1", err); end
      if (mon_en.size() !== 0) begin fails++; $display("FAIL parity_no_en: got %0d pulses required 0", mon_en.size()); end
      if (in_ready !== 1'b1)   begin fails++; $display("FAIL parity_back_to_load: got %0b required 1", in_ready); end
      send_frame(0, 1'b0, 0, WPS - 1);
      in_valid = 1'b0;
      tick();
      tests += 2;
      if (mon_en.size() < 1 || mon_en[0] !== 2'b01 || mon_cfg[0] !== frm[0]) begin fails++; $display("FAIL parity_resend: got %0d pulses required en 01 frame %h", mon_en.size(), frm[0]); end
      if (err !== 1'b1) begin fails++; $display("FAIL parity_err_sticky: got %0b required 1", err); end
      send_frame(1, 1'b0, 0, WPS - 1);
      in_valid = 1'b0;
      wait_done(at);
      pulse_start();
      tests++;
      if (err !== 1'b0) begin fails++; $display("FAIL parity_err_clear: got %0b required 0", err); end
      for (int s = 0; s < NS; s++) send_frame(s, 1'b0, 0, WPS - 1);
      in_valid = 1'b0;
      wait_done(at);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_split_pattern();
      test_stall();
      test_reset_midload();
      test_start_ignored();
`ifdef LUT_CFG_CHECK_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
